// File: rtl/draw_game_pkg.sv
// rtl/draw_game_pkg.sv - colour constants, tile palette and cell indexing shared by draw_game_pipe
package draw_game_pkg;

    localparam logic [5:0] COLOR_BLACK = 6'b000000;
    localparam logic [5:0] COLOR_WHITE = 6'b111111;
    localparam logic [5:0] COLOR_FG    = 6'b001111;
    localparam logic [5:0] COLOR_FLASH = 6'b100100;

    // Entry 0 is never drawn: a zero tile has no glyph pixels.
    localparam logic [5:0] TILE_PALETTE [16] = '{
        6'b000000, 6'b111110, 6'b111101, 6'b111000,
        6'b110100, 6'b110000, 6'b110001, 6'b111100,
        6'b101100, 6'b101000, 6'b100100, 6'b011100,
        6'b001100, 6'b001110, 6'b000111, 6'b010111
    };

    function automatic logic [5:0] CELL_IDX(
        input logic [2:0]  row,
        input logic [2:0]  col,
        input int unsigned n
    );
        return 6'(32'(row) * n + 32'(col));
    endfunction

endpackage

// File: rtl/draw_game_flash.sv
// rtl/draw_game_flash.sv - per-cell flash counters, restarted when a newly applied grid changes a cell
module draw_game_flash #(
    parameter int GRID_N       = 4,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_start,
    input  logic                       apply,
    input  logic [GRID_N*GRID_N*4-1:0] old_grid,
    input  logic [GRID_N*GRID_N*4-1:0] new_grid,
    output logic [GRID_N*GRID_N*4-1:0] counters
);

    localparam int         CELLS      = GRID_N * GRID_N;
    localparam logic [3:0] FLASH_INIT = 4'(FLASH_FRAMES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counters <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < CELLS; i++) begin
                // A restart replaces that frame's decrement.
                if (apply && new_grid[i*4 +: 4] != old_grid[i*4 +: 4] && new_grid[i*4 +: 4] != 4'd0) begin
                    counters[i*4 +: 4] <= FLASH_INIT;
                end else if (counters[i*4 +: 4] != 4'd0) begin
                    counters[i*4 +: 4] <= counters[i*4 +: 4] - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/draw_numbers.sv
// rtl/draw_numbers.sv - tile glyph: the four value bits drawn as bars, MSB leftmost
module draw_numbers (
    input  logic [3:0] value,
    input  logic [5:0] x_off,
    input  logic [5:0] y_off,
    output logic       pixel
);

    always_comb begin
        pixel = 1'b0;
        if (y_off >= 6'd24 && y_off <= 6'd39) begin
            for (int i = 0; i < 4; i++) begin
                if (x_off >= 6'(8 + 12 * i) && x_off <= 6'(15 + 12 * i) && value[3 - i]) begin
                    pixel = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/draw_game_pipe.sv
// rtl/draw_game_pipe.sv - double-buffered 2048 board renderer with flashing tiles, 2-cycle pixel pipe
// Optional per-value glyph colours: DRAW_GAME_TILE_COLORS_EN.
module draw_game_pipe
    import draw_game_pkg::*;
#(
    parameter int GRID_N       = 4,
    parameter int CELL_LOG2    = 6,
    parameter int ORIGIN_X     = 128,
    parameter int ORIGIN_Y     = 128,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [GRID_N*GRID_N*4-1:0] grid_in,
    input  logic                       grid_load,
    input  logic                       frame_start,
    input  logic                       video_active,
    input  logic [9:0]                 x,
    input  logic [9:0]                 y,
    output logic [5:0]                 rrggbb
);

    localparam int          GW       = GRID_N * GRID_N * 4;
    localparam int          IDX_W    = $clog2(GRID_N * GRID_N);
    localparam int          BOARD_PX = GRID_N << CELL_LOG2;
    localparam logic [11:0] X_LO     = 12'(ORIGIN_X);
    localparam logic [11:0] X_HI     = 12'(ORIGIN_X + BOARD_PX);
    localparam logic [11:0] Y_LO     = 12'(ORIGIN_Y);
    localparam logic [11:0] Y_HI     = 12'(ORIGIN_Y + BOARD_PX);
    localparam logic [9:0]  OX       = 10'(ORIGIN_X);
    localparam logic [9:0]  OY       = 10'(ORIGIN_Y);

    logic [GW-1:0] shadow;
    logic [GW-1:0] display;
    logic [GW-1:0] next_display;
    logic [GW-1:0] counters;
    logic          pending;
    logic          apply;

    // A load in the same cycle as frame_start goes straight to the display.
    assign apply        = frame_start && (pending || grid_load);
    assign next_display = grid_load ? grid_in : shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            if (grid_load && !frame_start) begin
                shadow  <= grid_in;
                pending <= 1'b1;
            end
            if (apply) begin
                display <= next_display;
                pending <= 1'b0;
            end
        end
    end

    draw_game_flash #(
        .GRID_N       (GRID_N),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .apply       (apply),
        .old_grid    (display),
        .new_grid    (next_display),
        .counters    (counters)
    );

    // Stage 1: board-relative coordinates, cell address and outline detection.
    logic [9:0]           bx;
    logic [9:0]           by;
    logic [CELL_LOG2-1:0] x_off;
    logic [CELL_LOG2-1:0] y_off;
    logic                 in_board_c;
    logic                 outline_c;

    assign bx         = x - OX;
    assign by         = y - OY;
    assign x_off      = bx[CELL_LOG2-1:0];
    assign y_off      = by[CELL_LOG2-1:0];
    assign in_board_c = video_active
                        && {2'b00, x} >= X_LO && {2'b00, x} < X_HI
                        && {2'b00, y} >= Y_LO && {2'b00, y} < Y_HI;
    assign outline_c  = x_off == '0 || x_off == '1 || y_off == '0 || y_off == '1;

    logic       s1_in_board;
    logic       s1_outline;
    logic [2:0] s1_col;
    logic [2:0] s1_row;
    logic [5:0] s1_gx;
    logic [5:0] s1_gy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_board <= 1'b0;
            s1_outline  <= 1'b0;
            s1_col      <= '0;
            s1_row      <= '0;
            s1_gx       <= '0;
            s1_gy       <= '0;
        end else begin
            s1_in_board <= in_board_c;
            s1_outline  <= outline_c;
            s1_col      <= 3'(bx >> CELL_LOG2);
            s1_row      <= 3'(by >> CELL_LOG2);
            s1_gx       <= x_off[CELL_LOG2-1 -: 6];
            s1_gy       <= y_off[CELL_LOG2-1 -: 6];
        end
    end

    // Stage 2: cell lookup, glyph and colour priority.
    logic [IDX_W-1:0] cell_idx;
    logic [3:0]       s2_value;
    logic [3:0]       s2_count;
    logic             glyph;
    logic [5:0]       fg;
    logic [5:0]       pix_next;

    assign cell_idx = IDX_W'(CELL_IDX(s1_row, s1_col, GRID_N));
    assign s2_value = display[{cell_idx, 2'b00} +: 4];
    assign s2_count = counters[{cell_idx, 2'b00} +: 4];

    draw_numbers u_numbers (
        .value (s2_value),
        .x_off (s1_gx),
        .y_off (s1_gy),
        .pixel (glyph)
    );

`ifdef DRAW_GAME_TILE_COLORS_EN
    assign fg = TILE_PALETTE[s2_value];
`else
    assign fg = COLOR_FG;
`endif

    always_comb begin
        pix_next = COLOR_BLACK;
        if (!s1_in_board) begin
            pix_next = COLOR_BLACK;
        end else if (s1_outline) begin
            pix_next = COLOR_WHITE;
        end else if (glyph) begin
            pix_next = fg;
        end else if (s2_count != 4'd0 && s2_count[0]) begin
            pix_next = COLOR_FLASH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrggbb <= COLOR_BLACK;
        end else begin
            rrggbb <= pix_next;
        end
    end

endmodule

// File: tb/tb_draw_game_pipe.sv
// tb/tb_draw_game_pipe.sv - directed scoreboard bench for draw_game_pipe (default and 5x5 instances)
module tb_draw_game_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         grid_load;
    logic         frame_start;
    logic         video_active;
    logic [9:0]   x;
    logic [9:0]   y;
    logic [63:0]  grid_in;
    logic [99:0]  grid5;
    logic [5:0]   rrggbb;
    logic [5:0]   rrggbb5;

    draw_game_pipe u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .grid_in      (grid_in),
        .grid_load    (grid_load),
        .frame_start  (frame_start),
        .video_active (video_active),
        .x            (x),
        .y            (y),
        .rrggbb       (rrggbb)
    );

    draw_game_pipe #(
        .GRID_N       (5),
        .CELL_LOG2    (7),
        .ORIGIN_X     (0),
        .ORIGIN_Y     (0),
        .FLASH_FRAMES (8)
    ) u_dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .grid_in      (grid5),
        .grid_load    (grid_load),
        .frame_start  (frame_start),
        .video_active (video_active),
        .x            (x),
        .y            (y),
        .rrggbb       (rrggbb5)
    );

    localparam logic [5:0] BLK = 6'b000000;
    localparam logic [5:0] WHT = 6'b111111;
    localparam logic [5:0] FG  = 6'b001111;
    localparam logic [5:0] FLS = 6'b100100;

    typedef struct {
        logic [5:0] exp;
        bit         chk;
        logic [5:0] exp5;
        bit         chk5;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // One pixel clock: compare the output due now, then drive and queue this cycle's expectation.
    task automatic step(input logic [9:0] px, input logic [9:0] py, input logic va,
                        input logic fs, input logic gl,
                        input bit chk, input logic [5:0] exp,
                        input bit chk5, input logic [5:0] exp5, input string tag);
        exp_t e;
        exp_t n;
        @(negedge clk);
        if (sb.size() == 2) begin
            e = sb.pop_front();
            if (e.chk) begin
                checks++;
                assert (rrggbb === e.exp) else begin
                    errors++;
                    $error("FAIL %s observed=%b expected=%b", e.tag, rrggbb, e.exp);
                end
            end
            if (e.chk5) begin
                checks++;
                assert (rrggbb5 === e.exp5) else begin
                    errors++;
                    $error("FAIL %s observed=%b expected=%b", e.tag, rrggbb5, e.exp5);
                end
            end
        end
        x            = px;
        y            = py;
        video_active = va;
        frame_start  = fs;
        grid_load    = gl;
        n.exp  = exp;
        n.chk  = chk;
        n.exp5 = exp5;
        n.chk5 = chk5;
        n.tag  = tag;
        sb.push_back(n);
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic [5:0] exp, input string tag);
        step(px, py, 1'b1, 1'b0, 1'b0, 1'b1, exp, 1'b0, BLK, tag);
    endtask

    task automatic ctl(input logic fs, input logic gl);
        step(10'd0, 10'd0, 1'b0, fs, gl, 1'b0, BLK, 1'b0, BLK, "idle");
    endtask

    initial begin
        rst_n        = 1'b0;
        grid_load    = 1'b0;
        frame_start  = 1'b0;
        video_active = 1'b0;
        x            = '0;
        y            = '0;
        grid_in      = '0;
        grid5        = '0;
        repeat (3) @(negedge clk);
        checks++;
        assert (rrggbb === BLK) else begin
            errors++;
            $error("FAIL reset_out observed=%b expected=%b", rrggbb, BLK);
        end
        checks++;
        assert (rrggbb5 === BLK) else begin
            errors++;
            $error("FAIL reset_out5 observed=%b expected=%b", rrggbb5, BLK);
        end
        rst_n = 1'b1;

        // Latency and board edges
        pix(10'd128, 10'd133, WHT, "lat_left_edge");
        pix(10'd127, 10'd133, BLK, "lat_left_out");
        pix(10'd130, 10'd133, BLK, "lat_blank");
        step(10'd130, 10'd133, 1'b0, 1'b0, 1'b0, 1'b1, BLK, 1'b0, BLK, "lat_inactive");
        pix(10'd383, 10'd140, WHT, "lat_right_edge");
        pix(10'd384, 10'd140, BLK, "lat_right_out");

        // Double buffer: loads wait for frame_start, last load wins
        grid_in = 64'h1;
        ctl(1'b0, 1'b1);
        pix(10'd174, 10'd158, BLK, "dbuf_held");
        grid_in = 64'h2;
        ctl(1'b0, 1'b1);
        pix(10'd174, 10'd158, BLK, "dbuf_still_held");
        ctl(1'b1, 1'b0);
        pix(10'd162, 10'd158, FG, "dbuf_last_wins");
        pix(10'd174, 10'd158, BLK, "dbuf_first_gone");
        ctl(1'b1, 1'b0);
        pix(10'd174, 10'd158, FLS, "flash_cell0_cnt7");

        // Flash countdown on cell (1,2)
        grid_in = 64'h0300_0002;
        ctl(1'b0, 1'b1);
        ctl(1'b1, 1'b0);
        pix(10'd261, 10'd197, BLK, "flash_cnt8");
        for (int k = 1; k <= 8; k++) begin
            ctl(1'b1, 1'b0);
            pix(10'd261, 10'd197, ((8 - k) % 2 == 1) ? FLS : BLK, $sformatf("flash_cnt%0d", 8 - k));
            pix(10'd197, 10'd133, BLK, "flash_unchanged");
        end
        ctl(1'b1, 1'b0);
        pix(10'd261, 10'd197, BLK, "flash_steady");

        // Bypass: load and frame_start together, after a pending load
        grid_in = 64'h0300_0002;
        ctl(1'b0, 1'b1);
        grid_in = 64'h0340_0002;
        ctl(1'b1, 1'b1);
        pix(10'd214, 10'd222, FG, "bypass_glyph");
        pix(10'd197, 10'd197, BLK, "bypass_cnt8");
        ctl(1'b1, 1'b0);
        pix(10'd214, 10'd222, FG, "bypass_pending_clear");
        pix(10'd197, 10'd197, FLS, "bypass_cnt7");

        // Asynchronous reset with pixels in flight
        pix(10'd128, 10'd133, WHT, "pre_reset");
        pix(10'd128, 10'd133, WHT, "pre_reset");
        pix(10'd128, 10'd133, WHT, "pre_reset");
        @(posedge clk);
        #1;
        checks++;
        assert (rrggbb === WHT) else begin
            errors++;
            $error("FAIL in_flight observed=%b expected=%b", rrggbb, WHT);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (rrggbb === BLK) else begin
            errors++;
            $error("FAIL reset_async observed=%b expected=%b", rrggbb, BLK);
        end
        sb.delete();
        grid_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        pix(10'd162, 10'd158, BLK, "post_reset_cell0");
        pix(10'd214, 10'd222, BLK, "post_reset_cell5");
        pix(10'd197, 10'd197, BLK, "post_reset_cnt5");

        // 5x5 board, 128-pixel cells at the screen origin
        grid5[99:96] = 4'h8;
        ctl(1'b0, 1'b1);
        ctl(1'b1, 1'b0);
        step(10'd640, 10'd10, 1'b1, 1'b0, 1'b0, 1'b1, BLK, 1'b1, BLK, "p5_x640_out");
        step(10'd639, 10'd10, 1'b1, 1'b0, 1'b0, 1'b1, BLK, 1'b1, WHT, "p5_x639_outline");
        step(10'd532, 10'd572, 1'b1, 1'b0, 1'b0, 1'b1, BLK, 1'b1, FG, "p5_cell44_glyph");
        step(10'd532, 10'd520, 1'b1, 1'b0, 1'b0, 1'b1, BLK, 1'b1, BLK, "p5_cell44_cnt8");
        ctl(1'b1, 1'b0);
        step(10'd532, 10'd520, 1'b1, 1'b0, 1'b0, 1'b0, BLK, 1'b1, FLS, "p5_cell44_cnt7");
        ctl(1'b0, 1'b0);
        ctl(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
